// File: rtl/atm_sample_packer.sv
// -----------------------------------------------------------------------------
// atm_sample_packer
//
// Tags each completed ADC conversion with its channel index and end-of-frame
// bit and stores it in a first-word-fall-through FIFO for the readout side.
// Overflow is handled per frame: once a word is lost, the rest of that frame
// is discarded, and storage resumes at the next frame boundary.
//
// Optional feature (compile-time macro ATM_PACK_FRAME_COUNT_EN):
//   defined   - FRAME_COUNT counts stored words that carry LASTWORD=1 (wraps)
//   undefined - FRAME_COUNT is tied to 0 and the counter is not built
//
// Ports:
//   SAMPLE_CLK     in   sole clock
//   NRST_sync      in   asynchronous active-low reset
//   ENSAMP_sync    in   sampling enable
//   ADC_DONE       in   single-cycle conversion-complete strobe
//   ADC_DATA       in   conversion result, valid with ADC_DONE
//   ATMCHSEL_DATA  in   one-hot channel of the conversion (lowest bit wins)
//   LASTWORD       in   end-of-frame flag, aligned with ADC_DONE
//   CLR            in   synchronous flush (pointers, level, discard, OVERFLOW)
//   RD_EN          in   pop request
//   RD_DATA        out  head word {eof, ch[2:0], data}; holds while empty
//   EMPTY / FULL   out  FIFO status
//   LEVEL          out  occupancy 0..DEPTH
//   OVERFLOW       out  sticky, set when any word is dropped
//   FRAME_COUNT    out  completed frames stored
// -----------------------------------------------------------------------------
module atm_sample_packer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                SAMPLE_CLK,
    input  logic                NRST_sync,
    input  logic                ENSAMP_sync,
    input  logic                ADC_DONE,
    input  logic [DATA_W-1:0]   ADC_DATA,
    input  logic [7:0]          ATMCHSEL_DATA,
    input  logic                LASTWORD,
    input  logic                CLR,
    input  logic                RD_EN,
    output logic [DATA_W+3:0]   RD_DATA,
    output logic                EMPTY,
    output logic                FULL,
    output logic [ADDR_W:0]     LEVEL,
    output logic                OVERFLOW,
    output logic [7:0]          FRAME_COUNT
);

    localparam int WORD_W = DATA_W + 4;
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    // Lowest set bit wins for a malformed (non-one-hot) channel select.
    function automatic logic [2:0] f_ch_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic [WORD_W-1:0] r_rd_data;
    state_t            r_state;

    state_t            w_state_nxt;
    logic              w_cap;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_fire;
    logic              w_wr;
    logic              w_drop;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_level_nxt;
    logic [ADDR_W:0]   w_remain;
    logic [WORD_W-1:0] w_head_nxt;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_cap     = ENSAMP_sync & ADC_DONE & (ATMCHSEL_DATA != 8'd0);
    assign w_rd_fire = RD_EN & ~w_empty & ~CLR;
    assign w_word    = {LASTWORD, f_ch_index(ATMCHSEL_DATA), ADC_DATA};

    // ------------------------------------------------------------------
    // Discard FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) r_state <= ST_ACCEPT;
        else            r_state <= w_state_nxt;
    end

    // Discard FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (CLR || !ENSAMP_sync) begin
            w_state_nxt = ST_ACCEPT;
        end else begin
            case (r_state)
                // A lost final word closes the frame, so no discard is needed.
                ST_ACCEPT:  if (w_cap && w_full && !w_rd_fire && !LASTWORD)
                                w_state_nxt = ST_DISCARD;
                ST_DISCARD: if (w_cap && LASTWORD)
                                w_state_nxt = ST_ACCEPT;
                default:    w_state_nxt = ST_ACCEPT;
            endcase
        end
    end

    // Discard FSM: outputs (write / drop decision)
    always_comb begin
        w_wr   = 1'b0;
        w_drop = 1'b0;
        if (!CLR && w_cap) begin
            case (r_state)
                ST_ACCEPT: begin
                    if (!w_full || w_rd_fire) w_wr   = 1'b1;
                    else                      w_drop = 1'b1;
                end
                default: w_drop = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign w_rd_ptr_nxt = w_rd_fire ? (r_rd_ptr + ADDR_W'(1)) : r_rd_ptr;
    assign w_remain     = r_level - (ADDR_W + 1)'(w_rd_fire);
    assign w_level_nxt  = w_remain + (ADDR_W + 1)'(w_wr);

    // The head after this edge is the incoming word when nothing else remains;
    // otherwise it is already in memory at the advanced read pointer.
    assign w_head_nxt = (w_wr && (w_remain == '0)) ? w_word : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge SAMPLE_CLK) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
        end else if (CLR) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            if (w_drop) r_overflow <= 1'b1;
            // Output register holds its last value once the FIFO drains.
            if (w_level_nxt != '0) r_rd_data <= w_head_nxt;
        end
    end

`ifdef ATM_PACK_FRAME_COUNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync)             r_frame_cnt <= 8'd0;
        else if (CLR)               r_frame_cnt <= 8'd0;
        else if (w_wr && LASTWORD)  r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign FRAME_COUNT = r_frame_cnt;
`else
    assign FRAME_COUNT = 8'd0;
`endif

    assign RD_DATA  = r_rd_data;
    assign EMPTY    = w_empty;
    assign FULL     = w_full;
    assign LEVEL    = r_level;
    assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_atm_sample_packer.sv
module tb_atm_sample_packer;

    logic        clk;
    logic        NRST_sync;
    logic        ENSAMP_sync;
    logic        ADC_DONE;
    logic [15:0] ADC_DATA;
    logic [7:0]  ATMCHSEL_DATA;
    logic        LASTWORD;
    logic        CLR;
    logic        RD_EN;
    logic [19:0] RD_DATA;
    logic        EMPTY;
    logic        FULL;
    logic [3:0]  LEVEL;
    logic        OVERFLOW;
    logic [7:0]  FRAME_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    atm_sample_packer #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
        .SAMPLE_CLK    (clk),
        .NRST_sync     (NRST_sync),
        .ENSAMP_sync   (ENSAMP_sync),
        .ADC_DONE      (ADC_DONE),
        .ADC_DATA      (ADC_DATA),
        .ATMCHSEL_DATA (ATMCHSEL_DATA),
        .LASTWORD      (LASTWORD),
        .CLR           (CLR),
        .RD_EN         (RD_EN),
        .RD_DATA       (RD_DATA),
        .EMPTY         (EMPTY),
        .FULL          (FULL),
        .LEVEL         (LEVEL),
        .OVERFLOW      (OVERFLOW),
        .FRAME_COUNT   (FRAME_COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] mkword(input logic [15:0] d, input logic [2:0] ch, input logic eof);
        return {eof, ch, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] sel, input logic last);
        ADC_DONE = 1'b1; ADC_DATA = d; ATMCHSEL_DATA = sel; LASTWORD = last;
        tick;
        ADC_DONE = 1'b0; LASTWORD = 1'b0;
    endtask

    task automatic pop;
        RD_EN = 1'b1;
        tick;
        RD_EN = 1'b0;
    endtask

    task automatic do_clr;
        CLR = 1'b1;
        tick;
        CLR = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (RD_DATA !== 20'h0) begin n_fail++; $display("FAIL reset_rd_data got %h expected 00000", RD_DATA); end
        n_checks++; if (LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d expected 0", LEVEL); end
        n_checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b expected 1 0", EMPTY, FULL); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b expected 0", OVERFLOW); end
        n_checks++; if (FRAME_COUNT !== 8'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d expected 0", FRAME_COUNT); end
    endtask

    task automatic test_basic;
        push(16'h1234, 8'h01, 1'b0);
        n_checks++; if (RD_DATA !== 20'h01234) begin n_fail++; $display("FAIL basic_first_word got %h expected 01234", RD_DATA); end
        n_checks++; if (LEVEL !== 4'd1 || EMPTY !== 1'b0) begin n_fail++; $display("FAIL basic_level1 got %0d/%b expected 1/0", LEVEL, EMPTY); end
        push(16'h5678, 8'h04, 1'b1);
        n_checks++; if (RD_DATA !== 20'h01234) begin n_fail++; $display("FAIL basic_head_kept got %h expected 01234", RD_DATA); end
        n_checks++; if (LEVEL !== 4'd2) begin n_fail++; $display("FAIL basic_level2 got %0d expected 2", LEVEL); end
`ifdef ATM_PACK_FRAME_COUNT_EN
        n_checks++; if (FRAME_COUNT !== 8'd1) begin n_fail++; $display("FAIL basic_frame_count got %0d expected 1", FRAME_COUNT); end
`else
        n_checks++; if (FRAME_COUNT !== 8'd0) begin n_fail++; $display("FAIL basic_frame_count got %0d expected 0", FRAME_COUNT); end
`endif
        pop;
        n_checks++; if (RD_DATA !== 20'hA5678) begin n_fail++; $display("FAIL basic_second_word got %h expected a5678", RD_DATA); end
        pop;
        n_checks++; if (EMPTY !== 1'b1 || LEVEL !== 4'd0) begin n_fail++; $display("FAIL basic_drained got %b/%0d expected 1/0", EMPTY, LEVEL); end
        n_checks++; if (RD_DATA !== 20'hA5678) begin n_fail++; $display("FAIL basic_hold_empty got %h expected a5678", RD_DATA); end
        pop;
        n_checks++; if (LEVEL !== 4'd0 || RD_DATA !== 20'hA5678) begin n_fail++; $display("FAIL basic_underflow got %0d/%h expected 0/a5678", LEVEL, RD_DATA); end
    endtask

    task automatic test_overflow;
        logic [19:0] exp_w;
        do_clr;
        for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 8'h01 << i, 1'b0);
        n_checks++; if (LEVEL !== 4'd8 || FULL !== 1'b1) begin n_fail++; $display("FAIL ovf_fill got %0d/%b expected 8/1", LEVEL, FULL); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet got %b expected 0", OVERFLOW); end
        push(16'hDEAD, 8'h01, 1'b0);
        n_checks++; if (LEVEL !== 4'd8 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_drop1 got %0d/%b expected 8/1", LEVEL, OVERFLOW); end
        pop;
        n_checks++; if (LEVEL !== 4'd7) begin n_fail++; $display("FAIL ovf_pop got %0d expected 7", LEVEL); end
        push(16'hDEAE, 8'h01, 1'b0);
        n_checks++; if (LEVEL !== 4'd7) begin n_fail++; $display("FAIL ovf_drop2_with_space got %0d expected 7", LEVEL); end
        push(16'hDEAF, 8'h01, 1'b1);
        n_checks++; if (LEVEL !== 4'd7) begin n_fail++; $display("FAIL ovf_drop3_last got %0d expected 7", LEVEL); end
        push(16'hBEEF, 8'h02, 1'b0);
        n_checks++; if (LEVEL !== 4'd8) begin n_fail++; $display("FAIL ovf_next_frame got %0d expected 8", LEVEL); end
        for (int i = 0; i < 8; i++) begin
            exp_w = (i < 7) ? mkword(16'h0101 + 16'(i), 3'(i + 1), 1'b0) : mkword(16'hBEEF, 3'd1, 1'b0);
            n_checks++; if (RD_DATA !== exp_w) begin n_fail++; $display("FAIL ovf_order[%0d] got %h expected %h", i, RD_DATA, exp_w); end
            pop;
        end
        n_checks++; if (EMPTY !== 1'b1 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b/%b expected 1/1", EMPTY, OVERFLOW); end
    endtask

    task automatic test_simul_rw;
        logic [19:0] exp_w;
        do_clr;
        for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 8'h01, 1'b0);
        RD_EN = 1'b1;
        push(16'h02FF, 8'h01, 1'b0);
        RD_EN = 1'b0;
        n_checks++; if (LEVEL !== 4'd8 || FULL !== 1'b1) begin n_fail++; $display("FAIL rw_full_level got %0d/%b expected 8/1", LEVEL, FULL); end
        n_checks++; if (RD_DATA !== 20'h00201) begin n_fail++; $display("FAIL rw_full_head got %h expected 00201", RD_DATA); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL rw_full_no_ovf got %b expected 0", OVERFLOW); end
        for (int i = 0; i < 8; i++) begin
            exp_w = (i < 7) ? mkword(16'h0201 + 16'(i), 3'd0, 1'b0) : 20'h002FF;
            n_checks++; if (RD_DATA !== exp_w) begin n_fail++; $display("FAIL rw_order[%0d] got %h expected %h", i, RD_DATA, exp_w); end
            pop;
        end
        n_checks++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL rw_drained got %b expected 1", EMPTY); end
        RD_EN = 1'b1;
        push(16'h0333, 8'h08, 1'b0);
        RD_EN = 1'b0;
        n_checks++; if (LEVEL !== 4'd1 || EMPTY !== 1'b0) begin n_fail++; $display("FAIL rw_empty_level got %0d/%b expected 1/0", LEVEL, EMPTY); end
        n_checks++; if (RD_DATA !== 20'h30333) begin n_fail++; $display("FAIL rw_empty_word got %h expected 30333", RD_DATA); end
    endtask

    task automatic test_ignored;
        push(16'h0EEE, 8'h00, 1'b0);
        n_checks++; if (LEVEL !== 4'd1 || OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ign_zero_sel got %0d/%b expected 1/0", LEVEL, OVERFLOW); end
        ENSAMP_sync = 1'b0;
        push(16'h0EEF, 8'h01, 1'b0);
        n_checks++; if (LEVEL !== 4'd1 || OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ign_disabled got %0d/%b expected 1/0", LEVEL, OVERFLOW); end
        n_checks++; if (RD_DATA !== 20'h30333) begin n_fail++; $display("FAIL ign_retained got %h expected 30333", RD_DATA); end
        ENSAMP_sync = 1'b1;
        push(16'h0444, 8'h0C, 1'b0);
        n_checks++; if (LEVEL !== 4'd2) begin n_fail++; $display("FAIL ign_multi_hot_level got %0d expected 2", LEVEL); end
        pop;
        n_checks++; if (RD_DATA !== 20'h20444) begin n_fail++; $display("FAIL ign_multi_hot_word got %h expected 20444", RD_DATA); end
    endtask

    task automatic test_wrap;
        logic [19:0] q[$];
        logic [19:0] w;
        logic        popping;
        do_clr;
        for (int k = 0; k < 10; k++) begin
            w = mkword(16'h0A00 + 16'(k), 3'(k % 8), (k == 9));
            ADC_DONE = 1'b1; ADC_DATA = 16'h0A00 + 16'(k);
            ATMCHSEL_DATA = 8'h01 << (k % 8); LASTWORD = (k == 9);
            RD_EN = (k % 2 == 1);
            popping = RD_EN && (q.size() > 0);
            if (popping) begin
                n_checks++; if (RD_DATA !== q[0]) begin n_fail++; $display("FAIL wrap_head[%0d] got %h expected %h", k, RD_DATA, q[0]); end
            end
            tick;
            if (popping) void'(q.pop_front());
            q.push_back(w);
            n_checks++; if (LEVEL !== 4'(q.size()) || LEVEL > 4'd8) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d expected %0d", k, LEVEL, q.size()); end
        end
        ADC_DONE = 1'b0; LASTWORD = 1'b0;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            n_checks++; if (RD_DATA !== q[0]) begin n_fail++; $display("FAIL wrap_drain got %h expected %h", RD_DATA, q[0]); end
            pop;
            void'(q.pop_front());
        end
        n_checks++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b expected 1", EMPTY); end
    endtask

    task automatic test_clr_discard;
        do_clr;
        for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i), 8'h01, 1'b0);
        push(16'h0DDD, 8'h01, 1'b0);
        pop; pop; pop;
        n_checks++; if (LEVEL !== 4'd5 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL clr_setup got %0d/%b expected 5/1", LEVEL, OVERFLOW); end
        CLR = 1'b1; RD_EN = 1'b1;
        push(16'h0CCC, 8'h01, 1'b0);
        CLR = 1'b0; RD_EN = 1'b0;
        n_checks++; if (LEVEL !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL clr_flush got %0d/%b/%b expected 0/1/0", LEVEL, EMPTY, FULL); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %b expected 0", OVERFLOW); end
        push(16'h0777, 8'h10, 1'b0);
        n_checks++; if (LEVEL !== 4'd1 || RD_DATA !== 20'h40777) begin n_fail++; $display("FAIL clr_accept got %0d/%h expected 1/40777", LEVEL, RD_DATA); end
    endtask

    task automatic test_frame_count;
        do_clr;
        n_checks++; if (FRAME_COUNT !== 8'd0) begin n_fail++; $display("FAIL fc_clr got %0d expected 0", FRAME_COUNT); end
        push(16'h0001, 8'h01, 1'b0);
        push(16'h0002, 8'h02, 1'b1);
        push(16'h0003, 8'h01, 1'b1);
        push(16'h0004, 8'h01, 1'b1);
`ifdef ATM_PACK_FRAME_COUNT_EN
        n_checks++; if (FRAME_COUNT !== 8'd3) begin n_fail++; $display("FAIL fc_count got %0d expected 3", FRAME_COUNT); end
`else
        n_checks++; if (FRAME_COUNT !== 8'd0) begin n_fail++; $display("FAIL fc_count got %0d expected 0", FRAME_COUNT); end
`endif
        n_checks++; if (LEVEL !== 4'd4) begin n_fail++; $display("FAIL fc_level got %0d expected 4", LEVEL); end
    endtask

    task automatic test_async_reset;
        push(16'h0055, 8'h01, 1'b0);
        @(posedge clk);
        #3;
        NRST_sync = 1'b0;
        #1;
        n_checks++; if (LEVEL !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL arst_level got %0d/%b/%b expected 0/1/0", LEVEL, EMPTY, FULL); end
        n_checks++; if (RD_DATA !== 20'h0 || OVERFLOW !== 1'b0 || FRAME_COUNT !== 8'd0) begin n_fail++; $display("FAIL arst_outputs got %h/%b/%0d expected 00000/0/0", RD_DATA, OVERFLOW, FRAME_COUNT); end
        tick;
        NRST_sync = 1'b1;
        tick;
        push(16'h0066, 8'h01, 1'b0);
        n_checks++; if (LEVEL !== 4'd1 || RD_DATA !== 20'h00066) begin n_fail++; $display("FAIL arst_resume got %0d/%h expected 1/00066", LEVEL, RD_DATA); end
    endtask

    initial begin
        NRST_sync = 1'b0; ENSAMP_sync = 1'b1; ADC_DONE = 1'b0; ADC_DATA = '0;
        ATMCHSEL_DATA = '0; LASTWORD = 1'b0; CLR = 1'b0; RD_EN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        NRST_sync = 1'b1;
        tick;
        test_basic;
        test_overflow;
        test_simul_rw;
        test_ignored;
        test_wrap;
        test_clr_discard;
        test_frame_count;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_sample_packer.md
Name: atm_sample_packer

Overview:
- Downstream consumer of the channel sequencer's data-aligned outputs (ATMCHSEL_DATA, LASTWORD) and the ADC result/DONE strobe, all in the SAMPLE_CLK domain.
- On each DONE, tags the ADC result with its 3-bit channel index and an end-of-frame bit, then pushes the word into a first-word-fall-through FIFO read by the readout interface.
- Handles overflow at frame granularity: the remainder of a corrupted frame is discarded, and storage resumes at the next frame boundary.

Parameters:
- DATA_W, 16, ADC result width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- SAMPLE_CLK  in  1  sole clock.
- NRST_sync  in  1  reset; asynchronous assert, active-low.
- ENSAMP_sync  in  1  sampling enable.
- ADC_DONE  in  1  single-cycle conversion-complete strobe.
- ADC_DATA  in  DATA_W  conversion result, valid with ADC_DONE.
- ATMCHSEL_DATA  in  8  one-hot channel of the completed conversion, aligned with ADC_DONE.
- LASTWORD  in  1  end-of-frame flag, aligned with ADC_DONE.
- CLR  in  1  synchronous flush: pointers, level, discard state and OVERFLOW all cleared.
- RD_EN  in  1  pop request.
- RD_DATA  out  DATA_W+4  head word {eof, ch[2:0], data}.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- LEVEL  out  ADDR_W+1  occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky; set when any word is dropped.
- FRAME_COUNT  out  8  completed frames stored (see Optional Feature).

Behaviour:
- Reset: pointers 0, LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, FRAME_COUNT=0, RD_DATA=0, discard state = ACCEPT.
- Capture condition: cap = ENSAMP_sync & ADC_DONE & (ATMCHSEL_DATA != 0).
  - Zero ATMCHSEL_DATA means the word is ignored silently.
  - Non-one-hot ATMCHSEL_DATA encodes the lowest set bit.
- Word format: RD_DATA[DATA_W+3] = LASTWORD; RD_DATA[DATA_W+2:DATA_W] = channel index; low bits = ADC_DATA.
- Write is accepted when cap & state==ACCEPT & (!FULL | rd_fire).
- Push latency: word is visible on RD_DATA and EMPTY falls on the cycle after the ADC_DONE edge, when the FIFO was empty.
- Read: rd_fire = RD_EN & !EMPTY.
  - RD_DATA always presents the head entry (FWFT).
  - Pop takes effect at the clock edge.
  - RD_EN while EMPTY is ignored, with no underflow flag.
  - RD_DATA holds its last value while EMPTY.
- Simultaneous read+write:
  - When FULL, the write is accepted; LEVEL stays DEPTH.
  - When EMPTY, only the write occurs; LEVEL becomes 1.
- Pointers wrap modulo DEPTH. FULL = (LEVEL==DEPTH); EMPTY = (LEVEL==0).
- Discard state machine, 2 states:
  - ACCEPT -> DISCARD: cap while FULL & !rd_fire. The word is dropped and OVERFLOW is set. If that word has LASTWORD=1, the FSM stays in ACCEPT instead, because the frame has ended.
  - DISCARD: every cap word is dropped, whether or not space is available.
  - DISCARD -> ACCEPT: on a cap word with LASTWORD=1 (that word is dropped), or when ENSAMP_sync=0, or on CLR.
- OVERFLOW clears only on CLR or reset.
- CLR takes priority over a same-cycle write and read. The FIFO is empty on the next cycle.
- ENSAMP_sync=0:
  - No new captures.
  - FIFO contents are retained and remain readable.
  - Discard state returns to ACCEPT.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); stored words are lost.

Optional Feature:
- Macro: ATM_PACK_FRAME_COUNT_EN.
- Defined:
  - FRAME_COUNT increments by 1 on every accepted write with LASTWORD=1.
  - 8-bit counter, wraps 255->0.
  - Cleared by CLR or reset.
- Undefined: FRAME_COUNT is tied to 0 and the counter logic is absent.

Test Plan:
- Reset then push CHEN 0x05 frames, ADC_DATA 0x1234 on ch0 (LASTWORD=0) then 0x5678 on ch2 (LASTWORD=1) -> RD_DATA 0x01234 then 0xA5678, LEVEL 1 then 2; FRAME_COUNT=1 with the macro defined.
- Fill DEPTH=8 with no reads, then a DONE mid-frame followed by 2 more words ending with LASTWORD=1 -> all 3 dropped, OVERFLOW=1, LEVEL=8; next frame's first word accepted once space exists.
- FULL with RD_EN and DONE in the same cycle -> write accepted, LEVEL stays 8, head advances; EMPTY with RD_EN and DONE -> LEVEL=1, no underflow.
- DONE with ATMCHSEL_DATA=0x00, or with ENSAMP_sync=0 -> no write, LEVEL unchanged, OVERFLOW unchanged.
- Push 10 words while popping 1 per 2 cycles to exercise pointer wrap -> output order matches input order exactly; LEVEL never exceeds 8.
- CLR while in DISCARD with LEVEL=5 -> next cycle LEVEL=0, EMPTY=1, OVERFLOW=0, state ACCEPT. Assert NRST_sync low mid-stream -> outputs return to reset values asynchronously.
